instr_mem_ctrl: RTL



---
 rtl/instr_mem_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/instr_mem_ctrl.sv
// Instruction-side memory controller.
// Serves the fetch stage's req/gnt/valid interface from a single-port
// synchronous SRAM. A programmable number of wait states can be inserted
// before each read. A low-priority loader write port shares the SRAM and
// yields whenever a fetch read occupies the port.
module instr_mem_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 14,
    parameter logic [31:0] MEM_BASE    = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 0          // legal range 0..15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    // fetch port
    input  logic                  instr_req,
    input  logic [31:0]           instr_addr,
    output logic                  instr_gnt,
    output logic [31:0]           instr_rdata,
    output logic                  instr_err,
    output logic                  instr_valid,
    // loader write port
    input  logic                  load_req,
    input  logic [31:0]           load_addr,
    input  logic [31:0]           load_wdata,
    output logic                  load_gnt,
    // SRAM port
    output logic                  mem_ce,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA
    } state_t;

    // Size of the SRAM window in bytes; one bit wider so the compare never wraps.
    localparam logic [32:0] MEM_SPAN  = 33'd1 << (ADDR_WIDTH + 2);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_wait_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_in_range;

    logic [31:0]           w_f_off;
    logic                  w_f_in_range;
    logic [ADDR_WIDTH-1:0] w_f_idx;
    logic [31:0]           w_l_off;
    logic                  w_l_in_range;
    logic [ADDR_WIDTH-1:0] w_l_idx;
    logic                  w_rd_issue;

    // Window decode for both ports: offset from the base, range flag, word index.
    // An address below MEM_BASE underflows to a huge offset and so reads as out of range.
    assign w_f_off      = instr_addr - MEM_BASE;
    assign w_f_in_range = ({1'b0, w_f_off} < MEM_SPAN);
    assign w_f_idx      = w_f_off[ADDR_WIDTH+1:2];
    assign w_l_off      = load_addr - MEM_BASE;
    assign w_l_in_range = ({1'b0, w_l_off} < MEM_SPAN);
    assign w_l_idx      = w_l_off[ADDR_WIDTH+1:2];

    // State register plus the per-transaction context latched on every grant.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'd0;
            r_addr     <= '0;
            r_in_range <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (instr_gnt) begin
                r_addr     <= w_f_idx;
                r_in_range <= w_f_in_range;
                r_wait_cnt <= WAIT_INIT;
            end else if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
        end
    end

    // Next-state, fetch response, and SRAM port arbitration (fetch read beats loader write).
    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_rd_issue  = 1'b0;
        instr_gnt   = 1'b0;
        instr_valid = 1'b0;
        instr_err   = 1'b0;
        instr_rdata = '0;
        load_gnt    = 1'b0;
        mem_ce      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;

        // Outputs are forced quiet while reset is held, even with requests pending.
        if (reset_n) begin
            case (r_state)
                ST_IDLE, ST_DATA: begin
                    // The DATA response belongs to the previously latched transaction.
                    if (r_state == ST_DATA) begin
                        instr_valid = 1'b1;
                        instr_err   = ~r_in_range;
                        instr_rdata = r_in_range ? mem_rdata : 32'd0;
                    end
                    instr_gnt = instr_req;
                    if (instr_req) begin
                        if (WAIT_CYCLES == 0) begin
                            w_rd_issue  = 1'b1;
                            mem_ce      = w_f_in_range;
                            mem_addr    = w_f_idx;
                            w_state_nxt = ST_DATA;
                        end else begin
                            w_state_nxt = ST_WAIT;
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt == 4'd1) begin
                        w_rd_issue  = 1'b1;
                        mem_ce      = r_in_range;
                        mem_addr    = r_addr;
                        w_state_nxt = ST_DATA;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase

            // The loader takes the SRAM only in cycles with no fetch read slot.
            // Out-of-range loads are accepted but never reach the SRAM.
            if (load_req && !w_rd_issue) begin
                load_gnt  = 1'b1;
                mem_ce    = w_l_in_range;
                mem_we    = w_l_in_range;
                mem_addr  = w_l_idx;
                mem_wdata = load_wdata;
            end
        end
    end

endmodule
